rv_instr_encoder_loader: RTL and testbench
==========================================

// Module: rv_instr_encoder_loader
// PURPOSE
// Encodes RV32I instructions from field form (op, rd, rs1, rs2, imm) into 32-bit words and writes
// them into instruction memory sequentially from address 0 after a start. It is the inverse of the
// control decoder and covers exactly its set: ADD SUB SRL AND OR SLT ADDI ORI XORI ANDI LW SW BEQ BNE JAL.
// Used to load test programs into the datapath's instruction memory.
// PARAMETERS
// ADDR_W   8   word-address width; capacity 2**ADDR_W instructions
// PORTS
// clk        in   1       clock, rising edge
// rst_n      in   1       reset, asynchronous, active-low
// start      in   1       begin a load at address 0; ignored unless idle
// in_valid   in   1       field set presented
// in_ready   out  1       encoder accepts field set
// in_op      in   4       op_e: 0 ADD,1 SUB,2 SRL,3 AND,4 OR,5 SLT,6 ADDI,7 ORI,8 XORI,9 ANDI,10 LW,11 SW,12 BEQ,13 BNE,14 JAL,15 rsvd
// in_rd      in   5       destination reg (ignored for SW/BEQ/BNE)
// in_rs1     in   5       source 1 (ignored for JAL)
// in_rs2     in   5       source 2 (R-type, SW, branches)
// in_imm     in   21      signed immediate in bytes
// in_last    in   1       final instruction of program
// mem_we     out  1       instruction-memory write strobe
// mem_addr   out  ADDR_W  word address
// mem_wdata  out  32      encoded instruction
// busy       out  1       load in progress
// done       out  1       one-cycle pulse at load end
// err        out  1       sticky error for current load, cleared on start
// err_addr   out  ADDR_W  address of first faulty word
// count      out  ADDR_W+1 words written in current load
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr, mem_wdata, err_addr, count = 0.
// - FSM IDLE -> LOAD on start. LOAD: in_ready=1, busy=1; on in_valid, register encoded word and last flag, go WRITE.
// - WRITE: in_ready=0, mem_we=1 for exactly one cycle with mem_addr/mem_wdata stable; count increments.
//   Then DONE if latched last or mem_addr==2**ADDR_W-1, otherwise LOAD with mem_addr+1.
// - DONE: done=1 for one cycle, busy=0 -> IDLE. Throughput is 1 word per 2 cycles; the write lands 1 cycle after acceptance.
// - Capacity overflow: reaching the last address without in_last ends the load. Set err, err_addr=last address.
// - Encoding: R-type funct7=0x20 for SUB, else 0; funct3 ADD/SUB 000, SRL 101, AND 111, OR 110, SLT 010;
//   I-type ADDI 000, ORI 110, XORI 100, ANDI 111; LW 0000011/f3 010; SW 0100011/f3 010;
//   BEQ 1100011/f3 000, BNE f3 001; JAL 1101111.
// - Immediate range: I/S imm in [-2048,2047]; B imm in [-4096,4094] and even; J imm in [-2^20,2^20-2] and even.
// - Range violation, odd B/J imm, or op 15: write NOP 0x00000013 instead. Set err; err_addr latches only the first fault.
// - start while busy: ignored. in_valid while not LOAD: not accepted, no side effects.
// - Reset mid-load: abort immediately to reset values. A partially written memory is not cleaned.
// STRUCTURE
// - Shared package rv_pkg: op_e enum; opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL);
//   funct3/funct7 constants; NOP_WORD.
// - Sub-module rv_instr_enc: purely combinational (op, rd, rs1, rs2, imm) -> (word, bad). The top holds the FSM, counters and error logic.
// TESTING
// - ADD x3,x1,x2 -> mem_wdata 0x002081B3 at addr 0. SUB x5,x6,x7 -> 0x407302B3 at addr 1.
// - ADDI x1,x0,5 -> 0x00500093; SW x2,8(x1) -> 0x0020A423; LW x4,-4(x1) -> 0xFFC0A203.
// - BEQ x1,x2,-4 -> 0xFE208EE3; JAL x1,8 with in_last -> 0x008000EF, then done pulse, count=2.
// - ADDI imm=2048 as 3rd word -> NOP 0x00000013 written, err=1, err_addr=2. A later BEQ imm=3 keeps err_addr=2.
// - ADDR_W=2, 5 words without in_last -> 4 writes, done after addr 3, err=1, err_addr=3, in_ready low.
// - rst_n low during WRITE -> mem_we drops asynchronously, all outputs 0; next start loads from addr 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and types for
// the instruction encoder/loader.
package rv_pkg;

  typedef enum logic [3:0] {
    I_ADD  = 4'd0,
    I_SUB  = 4'd1,
    I_SRL  = 4'd2,
    I_AND  = 4'd3,
    I_OR   = 4'd4,
    I_SLT  = 4'd5,
    I_ADDI = 4'd6,
    I_ORI  = 4'd7,
    I_XORI = 4'd8,
    I_ANDI = 4'd9,
    I_LW   = 4'd10,
    I_SW   = 4'd11,
    I_BEQ  = 4'd12,
    I_BNE  = 4'd13,
    I_JAL  = 4'd14,
    I_RSVD = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } ld_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/rv_instr_enc.sv
// Combinational RV32I field-to-word encoder.
// Out-of-range or reserved input yields NOP + bad.
module rv_instr_enc
  import rv_pkg::*;
(
  input  op_e         op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [20:0] imm_i,
  output logic [31:0] word_o,
  output logic        bad_o
);

  logic ok_12;
  logic ok_b;

  // 12-bit signed fit: bits 20..11 all equal
  assign ok_12 = (&imm_i[20:11]) | ~(|imm_i[20:11]);
  // 13-bit signed fit and even
  assign ok_b  = ((&imm_i[20:12]) | ~(|imm_i[20:12]))
               & ~imm_i[0];

  // Select format by op; any fault forces NOP
  always_comb begin
    word_o = NOP_WORD;
    bad_o  = 1'b0;
    unique case (op_i)
      I_ADD:  word_o = {F7_ZERO, rs2_i, rs1_i,
                        F3_ADD, rd_i, OP_R};
      I_SUB:  word_o = {F7_SUB, rs2_i, rs1_i,
                        F3_ADD, rd_i, OP_R};
      I_SRL:  word_o = {F7_ZERO, rs2_i, rs1_i,
                        F3_SRL, rd_i, OP_R};
      I_AND:  word_o = {F7_ZERO, rs2_i, rs1_i,
                        F3_AND, rd_i, OP_R};
      I_OR:   word_o = {F7_ZERO, rs2_i, rs1_i,
                        F3_OR, rd_i, OP_R};
      I_SLT:  word_o = {F7_ZERO, rs2_i, rs1_i,
                        F3_SLT, rd_i, OP_R};
      I_ADDI: begin
        word_o = {imm_i[11:0], rs1_i,
                  F3_ADD, rd_i, OP_I};
        bad_o  = ~ok_12;
      end
      I_ORI: begin
        word_o = {imm_i[11:0], rs1_i,
                  F3_OR, rd_i, OP_I};
        bad_o  = ~ok_12;
      end
      I_XORI: begin
        word_o = {imm_i[11:0], rs1_i,
                  F3_XOR, rd_i, OP_I};
        bad_o  = ~ok_12;
      end
      I_ANDI: begin
        word_o = {imm_i[11:0], rs1_i,
                  F3_AND, rd_i, OP_I};
        bad_o  = ~ok_12;
      end
      I_LW: begin
        word_o = {imm_i[11:0], rs1_i,
                  F3_LW, rd_i, OP_LOAD};
        bad_o  = ~ok_12;
      end
      I_SW: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i,
                  F3_SW, imm_i[4:0], OP_STORE};
        bad_o  = ~ok_12;
      end
      I_BEQ: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i,
                  rs1_i, F3_BEQ, imm_i[4:1],
                  imm_i[11], OP_BRANCH};
        bad_o  = ~ok_b;
      end
      I_BNE: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i,
                  rs1_i, F3_BNE, imm_i[4:1],
                  imm_i[11], OP_BRANCH};
        bad_o  = ~ok_b;
      end
      I_JAL: begin
        word_o = {imm_i[20], imm_i[10:1],
                  imm_i[11], imm_i[19:12],
                  rd_i, OP_JAL};
        bad_o  = imm_i[0];
      end
      default: bad_o = 1'b1;
    endcase
    if (bad_o) word_o = NOP_WORD;
  end

endmodule

// File: rtl/rv_instr_encoder_loader.sv
// Loads encoded RV32I words into instruction
// memory from address 0, one word per 2 cycles.
module rv_instr_encoder_loader
  import rv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [31:0] enc_word;
  logic        enc_bad;
  logic        accept;
  logic        at_end;

  rv_instr_enc u_enc (
    .op_i   (op_e'(in_op)),
    .rd_i   (in_rd),
    .rs1_i  (in_rs1),
    .rs2_i  (in_rs2),
    .imm_i  (in_imm),
    .word_o (enc_word),
    .bad_o  (enc_bad)
  );

  assign accept = (state_q == S_LOAD) & in_valid;
  assign at_end = last_q | (addr_q == ADDR_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)    state_d = S_LOAD;
      S_LOAD:  if (in_valid) state_d = S_WRITE;
      S_WRITE: state_d = at_end ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and strobe outputs from state
  always_comb begin
    in_ready = (state_q == S_LOAD);
    mem_we   = (state_q == S_WRITE);
    busy     = (state_q == S_LOAD)
             | (state_q == S_WRITE);
    done     = (state_q == S_DONE);
  end

  // Datapath next values: address, word, errors
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;
    eaddr_d = eaddr_q;
    cnt_d   = cnt_q;
    if ((state_q == S_IDLE) && start) begin
      addr_d  = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
      eaddr_d = '0;
      cnt_d   = '0;
    end
    if (accept) begin
      wdata_d = enc_word;
      last_d  = in_last;
      if (enc_bad) begin
        err_d = 1'b1;
        if (!err_q) eaddr_d = addr_q;
      end
    end
    if (state_q == S_WRITE) begin
      cnt_d = cnt_q + (ADDR_W+1)'(1);
      if (!at_end) addr_d = addr_q + ADDR_W'(1);
      if (!last_q && (addr_q == ADDR_MAX)) begin
        err_d = 1'b1;
        if (!err_q) eaddr_d = addr_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign err_addr  = eaddr_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_rv_instr_encoder_loader.sv
// Directed scoreboard bench for the encoder/loader
// (8-bit and 2-bit address instances).
module tb_rv_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2;
  logic        in_valid, in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [20:0] in_imm;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr, err_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [1:0]  mem_addr2, err_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  rv_instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err),
    .err_addr(err_addr), .count(count)
  );

  rv_instr_encoder_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .busy(busy2),
    .done(done2), .err(err2),
    .err_addr(err_addr2), .count(count2)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  wr_t e1, e2;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Scoreboard for the 8-bit instance
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (q1.size() == 0)
        chk("sb1_extra_write", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("sb1_addr", mem_addr, e1.a);
        chk("sb1_data", mem_wdata, e1.d);
      end
    end
  end

  // Scoreboard for the 2-bit instance
  always @(negedge clk) begin
    if (rst_n && mem_we2) begin
      if (q2.size() == 0)
        chk("sb2_extra_write", q2.size(), 1);
      else begin
        e2 = q2.pop_front();
        chk("sb2_addr", mem_addr2, e2.a);
        chk("sb2_data", mem_wdata2, e2.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 1) start = 1'b1;
    else          start2 = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input int sel,
                      input logic [3:0] op,
                      input logic [4:0] rd,
                      input logic [4:0] rs1,
                      input logic [4:0] rs2,
                      input logic [20:0] imm,
                      input logic last,
                      input logic [7:0] addr,
                      input logic [31:0] exp);
    int n = 0;
    while (!(sel == 1 ? in_ready : in_ready2)
           && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      chk("ready_timeout",
          sel == 1 ? in_ready : in_ready2, 1);
      return;
    end
    in_op = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    if (sel == 1) q1.push_back('{a: addr, d: exp});
    else          q2.push_back('{a: addr, d: exp});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n = 0;
    @(negedge clk);
    while (!(sel == 1 ? done : done2) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("done_pulse", sel == 1 ? done : done2, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_op = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_count", count, 0);
    chk("rst2_busy", busy2, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // in_valid while idle: nothing happens
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_count", count, 0);
    chk("idle_busy", busy, 0);
    tick();

    // Load A: mixed ops with two faults
    pulse_start(1);
    @(negedge clk);
    chk("loadA_ready", in_ready, 1);
    chk("loadA_busy", busy, 1);
    send(1, 4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 0,
         8'd0, 32'h002081B3);
    send(1, 4'd1, 5'd5, 5'd6, 5'd7, 21'd0, 0,
         8'd1, 32'h407302B3);
    start = 1'b1;
    tick();
    start = 1'b0;
    send(1, 4'd6, 5'd7, 5'd1, 5'd0, 21'd2048, 0,
         8'd2, 32'h00000013);
    @(negedge clk);
    chk("addi_range_err", err, 1);
    chk("addi_range_eaddr", err_addr, 2);
    send(1, 4'd12, 5'd0, 5'd1, 5'd2, 21'd3, 0,
         8'd3, 32'h00000013);
    @(negedge clk);
    chk("beq_odd_eaddr_kept", err_addr, 2);
    send(1, 4'd11, 5'd0, 5'd1, 5'd2, 21'd8, 0,
         8'd4, 32'h0020A423);
    send(1, 4'd10, 5'd4, 5'd1, 5'd0, -21'sd4, 0,
         8'd5, 32'hFFC0A203);
    send(1, 4'd12, 5'd0, 5'd1, 5'd2, -21'sd4, 0,
         8'd6, 32'hFE208EE3);
    send(1, 4'd14, 5'd1, 5'd0, 5'd0, 21'd8, 1,
         8'd7, 32'h008000EF);
    wait_done(1);
    chk("loadA_count", count, 8);
    chk("loadA_err", err, 1);
    chk("loadA_eaddr", err_addr, 2);
    chk("loadA_busy_done", busy, 0);
    chk("loadA_addr", mem_addr, 7);
    @(negedge clk);
    chk("loadA_done_1cyc", done, 0);
    tick();

    // Load B: err cleared on start
    pulse_start(1);
    @(negedge clk);
    chk("loadB_err_clr", err, 0);
    chk("loadB_cnt_clr", count, 0);
    send(1, 4'd6, 5'd1, 5'd0, 5'd0, 21'd5, 0,
         8'd0, 32'h00500093);
    send(1, 4'd14, 5'd1, 5'd0, 5'd0, 21'd8, 1,
         8'd1, 32'h008000EF);
    wait_done(1);
    chk("loadB_count", count, 2);
    chk("loadB_err", err, 0);
    tick();

    // Capacity overflow on 4-word instance
    pulse_start(2);
    send(2, 4'd3, 5'd1, 5'd2, 5'd3, 21'd0, 0,
         8'd0, 32'h003170B3);
    send(2, 4'd7, 5'd2, 5'd1, 5'd0, 21'h1FFFFF, 0,
         8'd1, 32'hFFF0E113);
    send(2, 4'd13, 5'd0, 5'd1, 5'd2, 21'd8, 0,
         8'd2, 32'h00209463);
    send(2, 4'd2, 5'd5, 5'd6, 5'd7, 21'd0, 0,
         8'd3, 32'h007352B3);
    wait_done(2);
    chk("ovf_err", err2, 1);
    chk("ovf_eaddr", err_addr2, 3);
    chk("ovf_count", count2, 4);
    chk("ovf_ready", in_ready2, 0);
    tick();
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_5th_ignored", count2, 4);
    chk("ovf_idle_ready", in_ready2, 0);
    tick();

    // Reserved op, then reset during WRITE
    pulse_start(1);
    send(1, 4'd15, 5'd1, 5'd1, 5'd1, 21'd0, 0,
         8'd0, 32'h00000013);
    chk("rsvd_we", mem_we, 1);
    chk("rsvd_nop", mem_wdata, 32'h00000013);
    chk("rsvd_err", err, 1);
    #1 rst_n = 1'b0;
    q1.delete();
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_count", count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(1);
    send(1, 4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1,
         8'd0, 32'h002081B3);
    wait_done(1);
    chk("post_rst_count", count, 1);
    tick();

    chk("sb1_drained", q1.size(), 0);
    chk("sb2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
